mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle/multi-cycle MIPS core; consumes the two register-file read operands (rdata1/rdata2) and holds results in private HI/LO registers.
- HI/LO are read back by MFHI/MFLO and written into the register file via the normal wdata path. They are written by MTHI/MTLO.
- One result per 33 cycles, with a start/busy/done handshake toward the control unit.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width (shared constant, same as register file).
- CNT_WIDTH, 5, iteration counter width (log2 DATA_WIDTH).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src_a  input  DATA_WIDTH  operand rs / multiplicand / dividend; also MTHI/MTLO data.
- src_b  input  DATA_WIDTH  operand rt / multiplier / divisor.
- mthi  input  1  write src_a to HI.
- mtlo  input  1  write src_a to LO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: HI/LO just updated.
- hi  output  DATA_WIDTH  HI register (MFHI source).
- lo  output  DATA_WIDTH  LO register (MFLO source).

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, HI=LO=0, busy=0, done=0, working regs 0. Reset mid-operation aborts; no partial HI/LO write.
- State machine:
  - IDLE: start=1 at edge E0 captures op, |src_a|, |src_b| (signed ops use absolute values), result signs, and enters CALC with counter=0.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
    - Counter increments each cycle. After the step with counter=31 (edge E32), go to FIX.
  - FIX: sign correction. Edge E33 writes HI/LO, returns to IDLE, and sets done=1 for exactly one cycle.
- busy=1 in CALC and FIX (visible after E0 through before E33); busy=0 in the done cycle.
- Latency: done and new HI/LO are visible in the cycle after E33, 33 cycles after the start edge.
- A new start is accepted in the same cycle done=1.
- Multiply result:
  - {HI,LO} = 64-bit product.
  - MULT: signed, two's-complement negated when operand signs differ.
  - MULTU: unsigned.
- Divide result: LO=quotient, HI=remainder.
  - DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
  - Divisor=0, either divide op: LO=32'hFFFFFFFF, HI=src_a (original dividend). Still takes the full 33 cycles.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0. No trap.
- start while busy: ignored, no effect.
- mthi/mtlo:
  - In IDLE with start=0: write src_a into HI/LO at the edge. Both may be asserted together.
  - While busy: ignored.
  - Same cycle as an accepted start: start wins, mthi/mtlo ignored.
- hi/lo outputs are direct register values (no combinational bypass).
- Operand inputs need only be stable in the start cycle; they are latched internally.

Decomposition:
- Shared package/header:
  - DATA_WIDTH
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings (MD_IDLE, MD_CALC, MD_FIX)
- Single natural sub-module: md_core_step, a combinational one-iteration datapath (shift-add / shift-subtract selectable). The top holds FSM, counter, sign fix-up and HI/LO.

Test Plan:
- Reset mid-op: MULTU 7×6, assert rst at cycle 10 → busy=0, done never pulses, hi=lo=0. Rerun after release → lo=42, hi=0.
- MULT signed: src_a=32'hFFFFFFFD (−3), src_b=5 at E0 → busy 1 for 33 cycles, done pulse once; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- MULTU max: src_a=src_b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV signed: −7 / 2 → lo=32'hFFFFFFFD (−3), hi=32'hFFFFFFFF (−1). Then DIVU 100 / 7 → lo=14, hi=2.
- Divide by zero and overflow:
  - DIVU 123 / 0 → lo=32'hFFFFFFFF, hi=123, latency 33.
  - DIV 32'h80000000 / −1 → lo=32'h80000000, hi=0.
- Handshake collisions:
  - start pulsed again while busy → ignored, single done.
  - mthi=1 with src_a=32'hDEADBEEF while busy → hi unchanged.
  - mthi+mtlo in IDLE → both = src_a next cycle.
  - start+mtlo together → mtlo dropped.
  - start in the done cycle → accepted.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants, operation/state encodings and small helpers for the
// iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Magnitude of a two's-complement operand; 32'h80000000 maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_WIDTH-1:0] md_abs(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  is_signed
  );
    if (is_signed && v[DATA_WIDTH-1]) begin
      md_abs = -v;
    end else begin
      md_abs = v;
    end
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    md_is_signed = (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_md_core_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide, on a {upper, lower} 64-bit working accumulator.
module md_core_step
  import mul_div_unit_pkg::*;
(
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0]   opnd,
  output logic [2*DATA_WIDTH-1:0] acc_out
);

  logic [DATA_WIDTH:0]   add_s;
  logic [DATA_WIDTH+1:0] sub_s;

  // Multiply keeps the multiplier in the lower half and shifts the partial
  // product in from the top; divide shifts the dividend into the remainder.
  always_comb begin
    add_s   = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, opnd};
    sub_s   = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH-1]} - {2'b00, opnd};
    acc_out = acc_in;
    if (is_div) begin
      if (sub_s[DATA_WIDTH+1] == 1'b0) begin
        acc_out = {sub_s[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_in[0]) begin
        acc_out = {add_s, acc_in[DATA_WIDTH-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[2*DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers; one
// result every 33 cycles behind a start/busy/done handshake.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  md_state_e               state_r;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic                    is_div_r;
  logic                    neg_q_r;
  logic                    neg_r_r;
  logic                    div0_r;
  logic [DATA_WIDTH-1:0]   opnd_r;
  logic [DATA_WIDTH-1:0]   dividend_r;
  logic [2*DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0]   hi_r;
  logic [DATA_WIDTH-1:0]   lo_r;
  logic                    busy_r;
  logic                    done_r;

  logic                    signed_s;
  logic [DATA_WIDTH-1:0]   a_abs_s;
  logic [DATA_WIDTH-1:0]   b_abs_s;
  logic [2*DATA_WIDTH-1:0] step_s;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH-1:0]   quo_s;
  logic [DATA_WIDTH-1:0]   rem_s;
  logic [DATA_WIDTH-1:0]   fix_hi_s;
  logic [DATA_WIDTH-1:0]   fix_lo_s;

  // Operand magnitudes for the launch edge.
  always_comb begin
    signed_s = md_is_signed(op);
    a_abs_s  = md_abs(src_a, signed_s);
    b_abs_s  = md_abs(src_b, signed_s);
  end

  md_core_step u_step (
    .is_div  (is_div_r),
    .acc_in  (acc_r),
    .opnd    (opnd_r),
    .acc_out (step_s)
  );

  // Sign fix-up and divide-by-zero override applied on the way into HI/LO.
  always_comb begin
    prod_s = neg_q_r ? -acc_r : acc_r;
    quo_s  = neg_q_r ? -acc_r[DATA_WIDTH-1:0] : acc_r[DATA_WIDTH-1:0];
    rem_s  = neg_r_r ? -acc_r[2*DATA_WIDTH-1:DATA_WIDTH]
                     : acc_r[2*DATA_WIDTH-1:DATA_WIDTH];
    if (is_div_r) begin
      if (div0_r) begin
        fix_hi_s = dividend_r;
        fix_lo_s = {DATA_WIDTH{1'b1}};
      end else begin
        fix_hi_s = rem_s;
        fix_lo_s = quo_s;
      end
    end else begin
      fix_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      fix_lo_s = prod_s[DATA_WIDTH-1:0];
    end
  end

  // Control FSM, iteration counter, working registers and HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= MD_IDLE;
      cnt_r      <= {CNT_WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div0_r     <= 1'b0;
      opnd_r     <= {DATA_WIDTH{1'b0}};
      dividend_r <= {DATA_WIDTH{1'b0}};
      acc_r      <= {(2*DATA_WIDTH){1'b0}};
      hi_r       <= {DATA_WIDTH{1'b0}};
      lo_r       <= {DATA_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= MD_CALC;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            busy_r     <= 1'b1;
            is_div_r   <= op[1];
            neg_q_r    <= signed_s & (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
            neg_r_r    <= signed_s & src_a[DATA_WIDTH-1];
            div0_r     <= (src_b == {DATA_WIDTH{1'b0}});
            dividend_r <= src_a;
            // Divide iterates the dividend; multiply iterates the multiplier.
            if (op[1]) begin
              acc_r  <= {{DATA_WIDTH{1'b0}}, a_abs_s};
              opnd_r <= b_abs_s;
            end else begin
              acc_r  <= {{DATA_WIDTH{1'b0}}, b_abs_s};
              opnd_r <= a_abs_s;
            end
          end else begin
            if (mthi) begin
              hi_r <= src_a;
            end
            if (mtlo) begin
              lo_r <= src_a;
            end
          end
        end
        MD_CALC: begin
          done_r <= 1'b0;
          acc_r  <= step_s;
          cnt_r  <= cnt_r + CNT_WIDTH'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= MD_FIX;
          end
        end
        MD_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= MD_IDLE;
        end
        default: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
